// File: rtl/door_pkg.sv
// door_pkg: shared state and fault-code types for the door plant model.
package door_pkg;
   typedef enum logic [1:0] {IDLE, UP, DN, FAULT} state_t;
   localparam int CODE_W = 2;
   typedef enum logic [CODE_W-1:0] {F_BOTH = 2'd0, F_OVERRUN = 2'd1, F_REVERSAL = 2'd2, F_STALL = 2'd3} fcode_t;
endpackage

// File: rtl/door_pos_ctr.sv
// door_pos_ctr: saturating up/down door position counter with end-of-travel flags.
module door_pos_ctr #(
   parameter int TRAVEL = 16,
   parameter int INIT = 0,
   localparam int POS_W = $clog2(TRAVEL + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   output logic [POS_W-1:0] pos,
   output logic             at_top,
   output logic             at_bottom
);
   assign at_top    = pos == POS_W'(TRAVEL);
   assign at_bottom = pos == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) pos <= POS_W'(INIT);
      else if (en && up && !at_top) pos <= pos + 1'b1;
      else if (en && !up && !at_bottom) pos <= pos - 1'b1;
endmodule

// File: rtl/door_plant.sv
// door_plant: plant-side door model turning motor drive into limit switches and misuse faults.
// Optional obstacle input and STALL fault when DOOR_PLANT_OBSTACLE_EN is defined.
module door_plant
   import door_pkg::*;
#(
   parameter int TRAVEL = 16,
   parameter int OVERRUN = 4,
   parameter bit INIT_AT_BOTTOM = 1'b1,
   localparam int POS_W = $clog2(TRAVEL + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              motor_up,
   input  logic              motor_dn,
   input  logic              fault_clr,
`ifdef DOOR_PLANT_OBSTACLE_EN
   input  logic              obstacle,
`endif
   output logic              up_limit,
   output logic              dn_limit,
   output logic [POS_W-1:0]  pos,
   output logic              moving,
   output logic              fault,
   output logic [CODE_W-1:0] fault_code
);
   localparam int CNT_W = $clog2(OVERRUN + 1);
   state_t state, state_nx;
   fcode_t code, code_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic pos_en, pos_up, at_top, at_bottom, blocked, up_req, dn_req, stuck_dn, full;
`ifdef DOOR_PLANT_OBSTACLE_EN
   assign blocked = obstacle;
`else
   assign blocked = 1'b0;
`endif
   door_pos_ctr #(.TRAVEL(TRAVEL), .INIT(INIT_AT_BOTTOM ? 0 : TRAVEL)) u_pos (
      .clk(clk), .rst(rst), .en(pos_en), .up(pos_up),
      .pos(pos), .at_top(at_top), .at_bottom(at_bottom)
   );
   assign up_limit   = at_top;
   assign dn_limit   = at_bottom;
   assign moving     = state == UP || state == DN;
   assign fault      = state == FAULT;
   assign fault_code = fault ? code : F_BOTH;
   assign stuck_dn   = at_bottom || blocked;
   assign full       = cnt == CNT_W'(OVERRUN - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         code  <= F_BOTH;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         code  <= code_nx;
         cnt   <= cnt_nx;
      end
   // The counter tracks consecutive edges spent driven but not moving (at a limit or blocked).
   always_comb begin
      state_nx = state;
      code_nx  = code;
      cnt_nx   = '0;
      pos_en   = 1'b0;
      pos_up   = 1'b0;
      up_req   = 1'b0;
      dn_req   = 1'b0;
      case (state)
         IDLE:
            if (motor_up && motor_dn) begin
               state_nx = FAULT;
               code_nx  = F_BOTH;
            end else begin
               up_req = motor_up;
               dn_req = motor_dn;
            end
         UP:
            if (motor_dn) begin
               state_nx = FAULT;
               code_nx  = F_REVERSAL;
            end else if (motor_up) up_req = 1'b1;
            else state_nx = IDLE;
         DN:
            if (motor_up) begin
               state_nx = FAULT;
               code_nx  = F_REVERSAL;
            end else if (motor_dn) dn_req = 1'b1;
            else state_nx = IDLE;
         default:
            state_nx = (fault_clr && !motor_up && !motor_dn) ? IDLE : FAULT;
      endcase
      if (up_req) begin
         state_nx = (at_top && full) ? FAULT : UP;
         code_nx  = (at_top && full) ? F_OVERRUN : code;
         pos_en   = !at_top;
         pos_up   = 1'b1;
         cnt_nx   = at_top ? cnt + 1'b1 : '0;
      end
      if (dn_req) begin
         state_nx = (stuck_dn && full) ? FAULT : DN;
         code_nx  = (stuck_dn && full) ? (blocked ? F_STALL : F_OVERRUN) : code;
         pos_en   = !stuck_dn;
         cnt_nx   = stuck_dn ? cnt + 1'b1 : '0;
      end
   end
endmodule

// File: tb/tb_door_plant.sv
// tb_door_plant: directed plus randomized checks of door_plant against a behavioural door model.
module tb_door_plant;
   localparam int T = 16;
   localparam int OV = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic motor_up = 1'b0, motor_dn = 1'b0, fault_clr = 1'b0, obstacle = 1'b0, obs_eff;
   logic up_limit, dn_limit, moving, fault;
   logic [4:0] pos;
   logic [1:0] fault_code;
   int n_chk = 0, n_pass = 0;
   int m_pos, m_dir, m_run, m_code;
   bit m_flt;
   always #5 clk = ~clk;
`ifdef DOOR_PLANT_OBSTACLE_EN
   assign obs_eff = obstacle;
`else
   assign obs_eff = 1'b0;
`endif
   door_plant #(.TRAVEL(T), .OVERRUN(OV), .INIT_AT_BOTTOM(1'b1)) dut (
      .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn), .fault_clr(fault_clr),
`ifdef DOOR_PLANT_OBSTACLE_EN
      .obstacle(obstacle),
`endif
      .up_limit(up_limit), .dn_limit(dn_limit), .pos(pos), .moving(moving),
      .fault(fault), .fault_code(fault_code)
   );
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask
   // Door model: position moves one step per driven edge unless held at an end or blocked.
   always @(posedge clk or posedge rst) begin
      int p, d, r, c;
      bit f;
      if (rst) begin
         m_pos <= 0; m_dir <= 0; m_run <= 0; m_flt <= 0; m_code <= 0;
      end else begin
         p = m_pos; d = m_dir; r = m_run; f = m_flt; c = m_code;
         if (f) begin
            if (fault_clr && !motor_up && !motor_dn) f = 0;
         end else if ((motor_up && motor_dn) || (d > 0 && motor_dn) || (d < 0 && motor_up)) begin
            f = 1;
            c = (d == 0) ? 0 : 2;
         end else if (motor_up) begin
            d = 1;
            if (p == T) r++;
            else begin p++; r = 0; end
            if (r >= OV) begin f = 1; c = 1; end
         end else if (motor_dn) begin
            d = -1;
            if (p == 0 || obs_eff) r++;
            else begin p--; r = 0; end
            if (r >= OV) begin f = 1; c = obs_eff ? 3 : 1; end
         end else begin
            d = 0; r = 0;
         end
         if (f) begin d = 0; r = 0; end
         m_pos <= p; m_dir <= d; m_run <= r; m_flt <= f; m_code <= c;
      end
   end
   always @(negedge clk)
      if (!rst) begin
         chk("pos", int'(pos), m_pos);
         chk("up_limit", int'(up_limit), int'(m_pos == T));
         chk("dn_limit", int'(dn_limit), int'(m_pos == 0));
         chk("moving", int'(moving), int'(m_dir != 0 && !m_flt));
         chk("fault", int'(fault), int'(m_flt));
         chk("fault_code", int'(fault_code), m_flt ? m_code : 0);
      end
   task automatic cyc(input logic u, input logic d, input logic c, input logic o = 1'b0);
      motor_up = u; motor_dn = d; fault_clr = c; obstacle = o;
      @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      chk("rst_pos", int'(pos), 0);
      chk("rst_dn_limit", int'(dn_limit), 1);
      chk("rst_up_limit", int'(up_limit), 0);
      chk("rst_fault", int'({fault, fault_code, moving}), 0);
      rst = 1'b0;
      cyc(1, 0, 0);
      chk("open_first_dn_limit", int'(dn_limit), 0);
      chk("open_first_pos", int'(pos), 1);
      repeat (T - 1) cyc(1, 0, 0);
      chk("open_pos", int'(pos), 16);
      chk("open_up_limit", int'(up_limit), 1);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("open_idle", int'({moving, fault}), 0);
      repeat (OV) cyc(1, 0, 0);
      chk("overrun_fault", int'(fault), 1);
      chk("overrun_code", int'(fault_code), 1);
      chk("overrun_pos", int'(pos), 16);
      cyc(1, 0, 1);
      chk("clr_ignored", int'(fault), 1);
      cyc(0, 0, 1);
      chk("clr_ok", int'(fault), 0);
      repeat (5) cyc(0, 1, 0);
      chk("rev_pos_before", int'(pos), 11);
      cyc(1, 0, 0);
      chk("rev_code", int'({fault, fault_code}), 3'b110);
      chk("rev_pos", int'(pos), 11);
      chk("rev_moving", int'(moving), 0);
      cyc(0, 0, 1);
      cyc(1, 1, 0);
      chk("both_code", int'({fault, fault_code}), 3'b100);
      chk("both_pos", int'(pos), 11);
      cyc(0, 0, 1);
      repeat (11) cyc(0, 1, 0);
      cyc(0, 0, 0);
      repeat (7) cyc(1, 0, 0);
      chk("mid_pos", int'(pos), 7);
      chk("mid_moving", int'(moving), 1);
      motor_up = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_pos", int'(pos), 0);
      chk("async_dn_limit", int'(dn_limit), 1);
      chk("async_idle", int'(moving), 0);
      #1 rst = 1'b0;
      @(negedge clk);
`ifdef DOOR_PLANT_OBSTACLE_EN
      repeat (10) cyc(1, 0, 0);
      cyc(0, 0, 0);
      repeat (2) cyc(0, 1, 0);
      repeat (3) cyc(0, 1, 0, 1);
      chk("obs_hold", int'(pos), 8);
      cyc(0, 1, 0, 0);
      chk("obs_resume", int'(pos), 7);
      chk("obs_nofault", int'(fault), 0);
      repeat (4) cyc(0, 1, 0, 1);
      chk("stall_code", int'({fault, fault_code}), 3'b111);
      cyc(0, 0, 1);
`endif
      for (int i = 0; i < 300; i++) begin
         automatic int cmd = $urandom_range(0, 9);
         automatic int len = $urandom_range(1, 24);
         for (int k = 0; k < len; k++)
            cyc(cmd inside {[1:4]}, cmd inside {[5:8]} || (cmd == 9 && k == 0),
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
